// File: rtl/pcma_symbol_gen.sv
// FM4/FM8 baseband I/Q burst source with optional second carrier.
// Drives lock-detector paths via a valid/ready handshake.
module pcma_symbol_gen #(
  parameter int DATA_WIDTH = 10,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            mode_i,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  burst_len_i,
  input  logic [DATA_WIDTH-2:0] amp_i,
  input  logic [DATA_WIDTH-2:0] amp2_i,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] I_data_o,
  output logic [DATA_WIDTH-1:0] Q_data_o,
  output logic                  data_val_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int AW = DATA_WIDTH - 1;
  localparam int PW = DATA_WIDTH + 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] MODE_FM4 = 3'b001;
  localparam logic [2:0] MODE_FM8 = 3'b010;

  localparam logic [14:0] SEED1 = 15'h7FFF;
  localparam logic [14:0] SEED2 = 15'h1234;

  function automatic logic [14:0] lfsr_step(
    input logic [14:0] s
  );
    return {s[13:0], s[14] ^ s[13]};
  endfunction

  // sin[k] is cos[k-2], so one table serves both axes
  function automatic logic signed [15:0] cos_lut(
    input logic [2:0] k
  );
    logic signed [15:0] c;
    unique case (k)
      3'd0:    c = 16'sd32767;
      3'd1:    c = 16'sd23170;
      3'd2:    c = 16'sd0;
      3'd3:    c = -16'sd23170;
      3'd4:    c = -16'sd32767;
      3'd5:    c = -16'sd23170;
      3'd6:    c = 16'sd0;
      default: c = 16'sd23170;
    endcase
    return c;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] scale(
    input logic [AW-1:0]     a,
    input logic signed [15:0] c
  );
    logic signed [PW-1:0] p;
    p = PW'($signed({1'b0, a})) * PW'(c);
    return DATA_WIDTH'(p >>> 15);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat(
    input logic signed [DATA_WIDTH:0] v
  );
    logic [DATA_WIDTH-1:0] r;
    if (v[DATA_WIDTH] != v[DATA_WIDTH-1])
      r = v[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                        : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      r = v[DATA_WIDTH-1:0];
    return r;
  endfunction

  logic [1:0]           state;
  logic [LEN_WIDTH-1:0] cnt;
  logic [14:0]          s1;
  logic [14:0]          s2;
  logic [2:0]           mode_q;
  logic [AW-1:0]        amp_q;
  logic [AW-1:0]        amp2_q;

  logic                 in_idle;
  logic [2:0]           mode_c;
  logic [AW-1:0]        amp_c;
  logic [AW-1:0]        amp2_c;
  logic                 fm8;
  logic [2:0]           k1;
  logic [2:0]           k2;
  logic signed [DATA_WIDTH-1:0] i1, q1, i2, q2;
  logic signed [DATA_WIDTH:0]   i_sum, q_sum;
  logic [DATA_WIDTH-1:0] i_sat, q_sat;
  logic                 mode_ok;
  logic                 accept;

  // In IDLE the first sample is built from live inputs, later from latched ones
  assign in_idle = (state == ST_IDLE);
  assign mode_c  = in_idle ? mode_i : mode_q;
  assign amp_c   = in_idle ? amp_i  : amp_q;
  assign amp2_c  = in_idle ? amp2_i : amp2_q;
  assign fm8     = (mode_c == MODE_FM8);

  assign k1 = fm8 ? s1[2:0] : {s1[1:0], 1'b1};
  assign k2 = fm8 ? s2[2:0] : {s2[1:0], 1'b1};

  assign i1 = scale(amp_c,  cos_lut(k1));
  assign q1 = scale(amp_c,  cos_lut(k1 - 3'd2));
  assign i2 = scale(amp2_c, cos_lut(k2));
  assign q2 = scale(amp2_c, cos_lut(k2 - 3'd2));

  assign i_sum = (DATA_WIDTH+1)'(i1) + (DATA_WIDTH+1)'(i2);
  assign q_sum = (DATA_WIDTH+1)'(q1) + (DATA_WIDTH+1)'(q2);
  assign i_sat = sat(i_sum);
  assign q_sat = sat(q_sum);

  assign mode_ok = (mode_i == MODE_FM4) || (mode_i == MODE_FM8);
  assign accept  = data_val_o && ready_i;
  assign busy_o  = (state == ST_RUN) || (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      s1         <= SEED1;
      s2         <= SEED2;
      mode_q     <= '0;
      amp_q      <= '0;
      amp2_q     <= '0;
      I_data_o   <= '0;
      Q_data_o   <= '0;
      data_val_o <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start_i && mode_ok) begin
            mode_q <= mode_i;
            amp_q  <= amp_i;
            amp2_q <= amp2_i;
            if (burst_len_i == '0) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
            end else begin
              state      <= ST_RUN;
              cnt        <= burst_len_i;
              I_data_o   <= i_sat;
              Q_data_o   <= q_sat;
              data_val_o <= 1'b1;
              s1         <= lfsr_step(s1);
              s2         <= lfsr_step(s2);
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (cnt > LEN_WIDTH'(1)) begin
              cnt      <= cnt - LEN_WIDTH'(1);
              I_data_o <= i_sat;
              Q_data_o <= q_sat;
              s1       <= lfsr_step(s1);
              s2       <= lfsr_step(s2);
            end else begin
              cnt        <= '0;
              data_val_o <= 1'b0;
              done_o     <= 1'b1;
              state      <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
